// File: rtl/smartcargo_pkg.sv
// Shared SmartCargo types: floor/type code widths, the packed transport
// request and a helper that builds a request from its raw fields.
package smartcargo_pkg;

  localparam int FLOOR_W = 2;
  localparam int TYPE_W  = 2;

  typedef struct packed {
    logic               eh_origem;  // origin == destination
    logic [TYPE_W-1:0]  tipo;
    logic [FLOOR_W-1:0] origem;
    logic [FLOOR_W-1:0] destino;
  } cargo_req_t;

  localparam int ENTRY_W = $bits(cargo_req_t);

  // Next-value source for one queue slot.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,  // keep current contents
    SEL_NEXT = 2'd1,  // take slot i+1 (pop shift down)
    SEL_PREV = 2'd2,  // take slot i-1 (fit shift up)
    SEL_NEW  = 2'd3   // load the incoming request
  } slot_sel_e;

  function automatic cargo_req_t make_req(input logic [TYPE_W-1:0]  tipo,
                                          input logic [FLOOR_W-1:0] origem,
                                          input logic [FLOOR_W-1:0] destino);
    cargo_req_t r;
    r.eh_origem = (origem == destino);
    r.tipo      = tipo;
    r.origem    = origem;
    r.destino   = destino;
    return r;
  endfunction

endpackage

// File: rtl/cargo_queue_slot.sv
// One queue slot: valid bit plus packed entry, updated from a 4-way source mux.
// Ports:
//   clk, clear              clock, synchronous active-high clear
//   sel                     next-value source (hold / next / prev / new)
//   next_valid, next_data   contents of slot i+1 (zero for the top slot)
//   prev_valid, prev_data   contents of slot i-1 (zero for slot 0)
//   new_data                incoming request; loading it marks the slot valid
//   valid, data             current slot contents
module cargo_queue_slot
  import smartcargo_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk,
  input  logic         clear,
  input  slot_sel_e    sel,
  input  logic         next_valid,
  input  logic [W-1:0] next_data,
  input  logic         prev_valid,
  input  logic [W-1:0] prev_data,
  input  logic [W-1:0] new_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_d;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid;
    data_d  = data;
    unique case (sel)
      SEL_NEXT: begin valid_d = next_valid; data_d = next_data; end
      SEL_PREV: begin valid_d = prev_valid; data_d = prev_data; end
      SEL_NEW:  begin valid_d = 1'b1;       data_d = new_data;  end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= valid_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/cargo_request_queue.sv
// Ordered transport-request queue for the SmartCargo elevator controller.
// Per cycle: pop first, then fit (ordered insert) or push on the post-pop
// queue, then an in-place overwrite if no other op is active.
// Ports:
//   clk, clear                      clock, synchronous active-high reset
//   in_tipo/in_origem/in_destino    request being written
//   push, pop, fit, fit_addr        queue ops; fit inserts at min(fit_addr, count)
//   we, wr_addr                     overwrite of a valid slot (idle cycles only)
//   rd_addr/ser_addr                registered read indices -> rd_*/ser_* outputs
//   sec_addr/sec_prev_addr          combinational destination lookups
//   count, empty, full              registered occupancy
//   overflow, underflow, conflict   one-cycle error pulses
// FLOOR_W/TYPE_W must match smartcargo_pkg; ENTRY_W is derived.
module cargo_request_queue #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int FLOOR_W = smartcargo_pkg::FLOOR_W,
  parameter int TYPE_W  = smartcargo_pkg::TYPE_W,
  parameter int ENTRY_W = 1 + TYPE_W + 2*FLOOR_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [TYPE_W-1:0]  in_tipo,
  input  logic [FLOOR_W-1:0] in_origem,
  input  logic [FLOOR_W-1:0] in_destino,
  input  logic               push,
  input  logic               pop,
  input  logic               fit,
  input  logic [ADDR_W-1:0]  fit_addr,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic [ADDR_W-1:0]  ser_addr,
  input  logic [ADDR_W-1:0]  sec_addr,
  input  logic [ADDR_W-1:0]  sec_prev_addr,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] ser_entry,
  output logic               ser_valid,
  output logic [FLOOR_W-1:0] sec_destino,
  output logic [FLOOR_W-1:0] sec_prev_destino,
  output logic [ADDR_W:0]    count,
  output logic               empty,
  output logic               full,
  output logic               overflow,
  output logic               underflow,
  output logic               conflict
);

  import smartcargo_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [DEPTH-1:0]              slot_valid;
  logic [DEPTH-1:0][ENTRY_W-1:0] slot_data;

  cargo_req_t       new_req;
  logic             do_pop, ins_req, ins_ok, we_ok;
  logic [ADDR_W:0]  cnt_pp, idx, count_d;
  logic [ADDR_W-1:0] rd_q, ser_q;

  assign new_req = make_req(in_tipo, in_origem, in_destino);

  // Op arbitration. cnt_pp is the occupancy after the pop stage; push and
  // fit both insert into that queue, push simply at its tail.
  always_comb begin
    do_pop  = pop && (count != '0);
    cnt_pp  = count - {{ADDR_W{1'b0}}, do_pop};
    ins_req = push || fit;
    ins_ok  = ins_req && (cnt_pp < DEPTH_C);
    idx     = (fit && ({1'b0, fit_addr} < cnt_pp)) ? {1'b0, fit_addr} : cnt_pp;
    we_ok   = we && !push && !pop && !fit && ({1'b0, wr_addr} < count);
    count_d = cnt_pp + {{ADDR_W{1'b0}}, ins_ok};
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [ADDR_W:0] I = (ADDR_W+1)'(i);

    slot_sel_e          sel;
    logic               nxt_v, prv_v;
    logic [ENTRY_W-1:0] nxt_d, prv_d;

    if (i == DEPTH-1) begin : g_top
      assign nxt_v = 1'b0;
      assign nxt_d = '0;
    end else begin : g_mid
      assign nxt_v = slot_valid[i+1];
      assign nxt_d = slot_data[i+1];
    end

    if (i == 0) begin : g_bot
      assign prv_v = 1'b0;
      assign prv_d = '0;
    end else begin : g_up
      assign prv_v = slot_valid[i-1];
      assign prv_d = slot_data[i-1];
    end

    // Slot i after the cycle = post-pop slot i below idx, new data at idx,
    // post-pop slot i-1 above idx. Post-pop slot i-1 is the current slot i
    // when popping, so the shift-down and shift-up cancel into a hold.
    always_comb begin
      sel = do_pop ? SEL_NEXT : SEL_HOLD;
      if (ins_ok && I == idx)                 sel = SEL_NEW;
      else if (ins_ok && I > idx)             sel = do_pop ? SEL_HOLD : SEL_PREV;
      else if (we_ok && I == {1'b0, wr_addr}) sel = SEL_NEW;
    end

    cargo_queue_slot #(.W(ENTRY_W)) u_slot (
      .clk        (clk),
      .clear      (clear),
      .sel        (sel),
      .next_valid (nxt_v),
      .next_data  (nxt_d),
      .prev_valid (prv_v),
      .prev_data  (prv_d),
      .new_data   (ENTRY_W'(new_req)),
      .valid      (slot_valid[i]),
      .data       (slot_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      conflict  <= 1'b0;
      rd_q      <= '0;
      ser_q     <= '0;
    end else begin
      count     <= count_d;
      empty     <= (count_d == '0);
      full      <= (count_d == DEPTH_C);
      overflow  <= ins_req && !ins_ok;
      underflow <= pop && (count == '0);
      conflict  <= (push && fit) || (we && !we_ok);
      rd_q      <= rd_addr;
      ser_q     <= ser_addr;
    end
  end

  // Registered index + lookup on the freshly updated slots gives
  // read-after-update with one cycle of address latency. Indices past
  // DEPTH match no slot and read as zero.
  always_comb begin
    rd_entry         = '0;
    rd_valid         = 1'b0;
    ser_entry        = '0;
    ser_valid        = 1'b0;
    sec_destino      = '0;
    sec_prev_destino = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (int'(rd_q) == j) begin
        rd_entry = slot_data[j];
        rd_valid = slot_valid[j];
      end
      if (int'(ser_q) == j) begin
        ser_entry = slot_data[j];
        ser_valid = slot_valid[j];
      end
      if (int'(sec_addr) == j && slot_valid[j])
        sec_destino = slot_data[j][FLOOR_W-1:0];
      if (int'(sec_prev_addr) == j && slot_valid[j])
        sec_prev_destino = slot_data[j][FLOOR_W-1:0];
    end
  end

endmodule

// File: tb/tb_cargo_request_queue.sv
module tb_cargo_request_queue;

  localparam int DEPTH = 16;

  logic       clk = 0;
  logic       clear;
  logic [1:0] in_tipo, in_origem, in_destino;
  logic       push, pop, fit, we;
  logic [3:0] fit_addr, wr_addr, rd_addr, ser_addr, sec_addr, sec_prev_addr;
  logic [6:0] rd_entry, ser_entry;
  logic       rd_valid, ser_valid;
  logic [1:0] sec_destino, sec_prev_destino;
  logic [4:0] count;
  logic       empty, full, overflow, underflow, conflict;

  cargo_request_queue dut (
    .clk(clk), .clear(clear),
    .in_tipo(in_tipo), .in_origem(in_origem), .in_destino(in_destino),
    .push(push), .pop(pop), .fit(fit), .fit_addr(fit_addr),
    .we(we), .wr_addr(wr_addr), .rd_addr(rd_addr), .ser_addr(ser_addr),
    .sec_addr(sec_addr), .sec_prev_addr(sec_prev_addr),
    .rd_entry(rd_entry), .rd_valid(rd_valid),
    .ser_entry(ser_entry), .ser_valid(ser_valid),
    .sec_destino(sec_destino), .sec_prev_destino(sec_prev_destino),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of packed entries, head at index 0.
  int mq[$];
  int m_ovf, m_unf, m_conf;
  int e_rd, e_rdv, e_ser, e_serv;

  function automatic int pack(int t, int o, int d);
    return ((o == d) ? 64 : 0) + t * 16 + o * 4 + d;
  endfunction

  function automatic int lookup(int a);
    return (a < mq.size()) ? mq[a] : 0;
  endfunction

  task automatic model_apply();
    int e, ix;
    m_ovf = 0; m_unf = 0; m_conf = 0;
    e = pack(in_tipo, in_origem, in_destino);
    if (clear) begin
      mq.delete();
    end else begin
      if (pop) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_unf = 1;
      end
      if (fit) begin
        if (push) m_conf = 1;
        if (mq.size() < DEPTH) begin
          ix = (int'(fit_addr) < mq.size()) ? int'(fit_addr) : mq.size();
          mq.insert(ix, e);
        end else m_ovf = 1;
      end else if (push) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
      end
      if (we) begin
        if (!push && !pop && !fit && int'(wr_addr) < mq.size()) mq[wr_addr] = e;
        else m_conf = 1;
      end
    end
    // Reads after an active reset see address zero.
    e_rd   = clear ? 0 : lookup(rd_addr);
    e_rdv  = clear ? 0 : int'(int'(rd_addr) < mq.size());
    e_ser  = clear ? 0 : lookup(ser_addr);
    e_serv = clear ? 0 : int'(int'(ser_addr) < mq.size());
  endtask

  task automatic tick();
    model_apply();
    @(posedge clk); #1;
    push = 0; pop = 0; fit = 0; we = 0; clear = 0;
  endtask

  task automatic set_req(int t, int o, int d);
    in_tipo = 2'(t); in_origem = 2'(o); in_destino = 2'(d);
  endtask

  // Entries used by directed tests.
  localparam logic [6:0] A = 7'h12;  // t1 o0 d2
  localparam logic [6:0] B = 7'h6F;  // t2 o3 d3, eh_origem
  localparam logic [6:0] C = 7'h07;  // t0 o1 d3
  localparam logic [6:0] D = 7'h38;  // t3 o2 d0
  localparam logic [6:0] E = 7'h55;  // t1 o1 d1, eh_origem

  task automatic test_reset();
    clear = 1; tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got e%b f%b exp e1 f0", empty, full); end
    checks++; if ({overflow, underflow, conflict} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {overflow, underflow, conflict}); end
    checks++; if (rd_entry !== 7'd0 || rd_valid !== 1'b0 || ser_entry !== 7'd0 || ser_valid !== 1'b0) begin errors++; $display("FAIL reset_reads got %h/%b %h/%b exp 0", rd_entry, rd_valid, ser_entry, ser_valid); end
  endtask

  task automatic test_push_basic();
    clear = 1; tick();
    set_req(1, 0, 2); push = 1; tick();
    set_req(2, 3, 3); push = 1; rd_addr = 1; ser_addr = 2; tick();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL push_count got %0d exp 2", count); end
    checks++; if (rd_entry !== B || rd_valid !== 1'b1) begin errors++; $display("FAIL push_slot1 got %h/%b exp %h/1", rd_entry, rd_valid, B); end
    checks++; if (ser_entry !== 7'd0 || ser_valid !== 1'b0) begin errors++; $display("FAIL push_slot2 got %h/%b exp 0/0", ser_entry, ser_valid); end
    sec_addr = 0; sec_prev_addr = 2; #1;
    checks++; if (sec_destino !== 2'd2 || sec_prev_destino !== 2'd0) begin errors++; $display("FAIL push_sec got %0d/%0d exp 2/0", sec_destino, sec_prev_destino); end
  endtask

  task automatic test_overflow();
    clear = 1; tick();
    for (int i = 0; i < DEPTH; i++) begin
      set_req($urandom_range(3), $urandom_range(3), $urandom_range(3)); push = 1; tick();
    end
    set_req(0, 0, 1); push = 1; tick();
    checks++; if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL ovf_pulse got o%b c%0d f%b exp o1 c16 f1", overflow, count, full); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b exp 0", overflow); end
    set_req(3, 1, 2); pop = 1; push = 1; rd_addr = 15; tick();
    checks++; if (count !== 5'd16 || overflow !== 1'b0 || rd_entry !== 7'h36) begin errors++; $display("FAIL ovf_pop_push got c%0d o%b %h exp c16 o0 36", count, overflow, rd_entry); end
  endtask

  task automatic test_fit();
    clear = 1; tick();
    set_req(1, 0, 2); push = 1; tick();
    set_req(2, 3, 3); push = 1; tick();
    set_req(0, 1, 3); push = 1; tick();
    set_req(3, 2, 0); fit = 1; fit_addr = 1; rd_addr = 1; ser_addr = 3; tick();
    checks++; if (count !== 5'd4 || rd_entry !== D || ser_entry !== C) begin errors++; $display("FAIL fit_mid got c%0d %h %h exp c4 %h %h", count, rd_entry, ser_entry, D, C); end
    set_req(1, 1, 1); fit = 1; fit_addr = 9; rd_addr = 4; ser_addr = 2; tick();
    checks++; if (count !== 5'd5 || rd_entry !== E || ser_entry !== B) begin errors++; $display("FAIL fit_clip got c%0d %h %h exp c5 %h %h", count, rd_entry, ser_entry, E, B); end
  endtask

  task automatic test_underflow();
    clear = 1; tick();
    pop = 1; tick();
    checks++; if (underflow !== 1'b1 || count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL unf_pulse got u%b c%0d exp u1 c0", underflow, count); end
    set_req(1, 0, 2); push = 1; tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_one_cycle got %b exp 0", underflow); end
    set_req(2, 3, 3); push = 1; tick();
    set_req(3, 2, 0); pop = 1; fit = 1; fit_addr = 0; rd_addr = 0; ser_addr = 1; tick();
    checks++; if (count !== 5'd2 || rd_entry !== D || ser_entry !== B) begin errors++; $display("FAIL pop_fit got c%0d %h %h exp c2 %h %h", count, rd_entry, ser_entry, D, B); end
  endtask

  task automatic test_conflict();
    clear = 1; tick();
    set_req(1, 0, 2); push = 1; tick();
    set_req(2, 3, 3); push = 1; tick();
    set_req(0, 1, 3); push = 1; tick();
    set_req(3, 2, 0); push = 1; fit = 1; fit_addr = 0; rd_addr = 0; tick();
    checks++; if (conflict !== 1'b1 || count !== 5'd4 || rd_entry !== D) begin errors++; $display("FAIL push_fit got x%b c%0d %h exp x1 c4 %h", conflict, count, rd_entry, D); end
    clear = 1; tick();
    set_req(1, 0, 2); push = 1; tick();
    set_req(2, 3, 3); push = 1; tick();
    set_req(0, 1, 3); push = 1; tick();
    set_req(1, 1, 1); we = 1; wr_addr = 5; ser_addr = 2; tick();
    checks++; if (conflict !== 1'b1 || count !== 5'd3 || ser_entry !== C) begin errors++; $display("FAIL we_drop got x%b c%0d %h exp x1 c3 %h", conflict, count, ser_entry, C); end
    set_req(1, 1, 1); we = 1; wr_addr = 1; ser_addr = 1; tick();
    checks++; if (conflict !== 1'b0 || count !== 5'd3 || ser_entry !== E || ser_valid !== 1'b1) begin errors++; $display("FAIL we_ok got x%b c%0d %h exp x0 c3 %h", conflict, count, ser_entry, E); end
  endtask

  task automatic test_clear_mid();
    clear = 1; tick();
    for (int i = 0; i < 7; i++) begin set_req(i % 4, 1, 2); push = 1; tick(); end
    set_req(2, 2, 2); push = 1; clear = 1; rd_addr = 0; ser_addr = 3; tick();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_entry !== 7'd0 || ser_entry !== 7'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL clear_mid got c%0d e%b %h %h", count, empty, rd_entry, ser_entry); end
    set_req(1, 0, 2); push = 1; tick();
    set_req(2, 3, 3); push = 1; tick();
    rd_addr = 1; #2;
    checks++; if (rd_entry !== A) begin errors++; $display("FAIL rd_latency_hold got %h exp %h", rd_entry, A); end
    tick();
    checks++; if (rd_entry !== B) begin errors++; $display("FAIL rd_latency_update got %h exp %h", rd_entry, B); end
  endtask

  task automatic test_random();
    int es, esp;
    clear = 1; tick();
    for (int n = 0; n < 2000; n++) begin
      clear    = ($urandom_range(99) == 0);
      push     = ($urandom_range(99) < 50);
      pop      = ($urandom_range(99) < 35);
      fit      = ($urandom_range(99) < 20);
      we       = ($urandom_range(99) < 20);
      fit_addr = 4'($urandom_range(15));
      wr_addr  = 4'($urandom_range(15));
      rd_addr  = 4'($urandom_range(15));
      ser_addr = 4'($urandom_range(15));
      set_req($urandom_range(3), $urandom_range(3), $urandom_range(3));
      tick();
      checks++; if (int'(count) != mq.size() || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_count n%0d got c%0d e%b f%b exp c%0d", n, count, empty, full, mq.size()); end
      checks++; if ({overflow, underflow, conflict} !== {m_ovf[0], m_unf[0], m_conf[0]}) begin errors++; $display("FAIL rnd_pulses n%0d got %b exp %0d%0d%0d", n, {overflow, underflow, conflict}, m_ovf, m_unf, m_conf); end
      checks++; if (rd_entry !== 7'(e_rd) || rd_valid !== e_rdv[0] || ser_entry !== 7'(e_ser) || ser_valid !== e_serv[0]) begin errors++; $display("FAIL rnd_reads n%0d got %h/%b %h/%b exp %h/%0d %h/%0d", n, rd_entry, rd_valid, ser_entry, ser_valid, e_rd, e_rdv, e_ser, e_serv); end
      sec_addr = 4'($urandom_range(15)); sec_prev_addr = 4'($urandom_range(15)); #1;
      es = lookup(sec_addr) % 4; esp = lookup(sec_prev_addr) % 4;
      checks++; if (sec_destino !== 2'(es) || sec_prev_destino !== 2'(esp)) begin errors++; $display("FAIL rnd_sec n%0d got %0d/%0d exp %0d/%0d", n, sec_destino, sec_prev_destino, es, esp); end
    end
  endtask

  initial begin
    clear = 0; push = 0; pop = 0; fit = 0; we = 0;
    in_tipo = 0; in_origem = 0; in_destino = 0;
    fit_addr = 0; wr_addr = 0; rd_addr = 0; ser_addr = 0; sec_addr = 0; sec_prev_addr = 0;
    test_reset();
    test_push_basic();
    test_overflow();
    test_fit();
    test_underflow();
    test_conflict();
    test_clear_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
